// File: rtl/flag_branch_ctrl_pkg.sv
// Shared opcode constants and FSM state encodings for the fetch/execute controller.
// Pure definitions; no logic, no latency, no flow control.
package proc_defs;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h2;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_JC     = 4'h8;
  localparam logic [3:0] OP_JNC    = 4'h9;
  localparam logic [3:0] OP_JZ     = 4'hA;
  localparam logic [3:0] OP_JNZ    = 4'hB;
  localparam logic [3:0] OP_JMP    = 4'hC;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/flag_branch_ctrl_branch_cond.sv
// Jump decode: flags whether op_q is a jump and whether its condition holds on C/Z.
// Purely combinational (zero latency); no flow control.
module branch_cond
  import proc_defs::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op_q,
  input  logic            flag_c,
  input  logic            flag_z,
  output logic            is_jump,
  output logic            cond
);

  always_comb begin
    is_jump = 1'b1;
    cond    = 1'b0;
    case (op_q)
      OP_W'(OP_JC):  cond = flag_c;
      OP_W'(OP_JNC): cond = !flag_c;
      OP_W'(OP_JZ):  cond = flag_z;
      OP_W'(OP_JNZ): cond = !flag_z;
      OP_W'(OP_JMP): cond = 1'b1;
      default:       is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Fetch/execute sequencer that reads C/Z to resolve jumps and drives PC/IR/flag strobes.
// One instruction per FETCH+EXEC pair; run=0 stalls in FETCH, HALT is left only by reset.
module flag_branch_ctrl
  import proc_defs::*;
#(
  parameter int OP_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic [OP_W-1:0]  instr_op,
  input  logic             flag_c,
  input  logic             flag_z,
  output logic             ir_load,
  output logic             flags_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             taken,
  output logic             halted,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic [OP_W-1:0] op_q;
  logic            is_jump;
  logic            cond;
  logic            is_alu;
  logic            is_hlt;

  branch_cond #(.OP_W(OP_W)) u_branch_cond (
    .op_q    (op_q),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .is_jump (is_jump),
    .cond    (cond)
  );

  assign is_alu = (op_q >= OP_W'(OP_ALU_LO)) && (op_q <= OP_W'(OP_ALU_HI));
  assign is_hlt = (op_q == OP_W'(OP_HLT));
  assign phase  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) begin
        op_q <= instr_op;
      end
      // taken is only ever asserted in EXEC, so this counts completed taken jumps
      if (taken && (taken_cnt != CNT_MAX)) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    flags_en  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    taken     = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (run) begin
          ir_load   = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        if (is_hlt) begin
          state_nxt = ST_HALT;
        end else if (is_alu) begin
          flags_en = 1'b1;
          pc_inc   = 1'b1;
        end else if (is_jump) begin
          pc_load = cond;
          pc_inc  = !cond;
          taken   = cond;
        end else begin
          pc_inc = 1'b1;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
